// File: rtl/serial_pkg.sv
// Shared constants and types for the EMC08 serial port control block.
package serial_pkg;

   localparam logic [7:0] DEF_SCON_ADDR = 8'h98;
   localparam logic [7:0] DEF_SBUF_ADDR = 8'h99;

   localparam logic [1:0] MODE0 = 2'd0;
   localparam logic [1:0] MODE1 = 2'd1;
   localparam logic [1:0] MODE2 = 2'd2;
   localparam logic [1:0] MODE3 = 2'd3;

   localparam int unsigned SCON_SM0 = 7;
   localparam int unsigned SCON_SM1 = 6;
   localparam int unsigned SCON_SM2 = 5;
   localparam int unsigned SCON_REN = 4;
   localparam int unsigned SCON_TB8 = 3;
   localparam int unsigned SCON_RB8 = 2;
   localparam int unsigned SCON_TI  = 1;
   localparam int unsigned SCON_RI  = 0;

   localparam int unsigned DIV_12 = 12;
   localparam int unsigned DIV_32 = 32;
   localparam int unsigned DIV_64 = 64;

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} tx_state_t;

endpackage

// File: rtl/serial_baud_gen.sv
// Baud tick divider: counts clocks (modes 0/2) or timer1 overflows (modes 1/3)
// and emits a one-cycle registered tick at the end of each period.
module serial_baud_gen
   import serial_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic [1:0] i_mode,
   input  logic       i_smod,
   input  logic       i_t1_ovf,
   output logic       o_br
);

   logic [5:0] r_cnt;
   logic       r_br;
   logic [5:0] w_last;
   logic       w_step;

   always_comb begin
      w_last = 6'(DIV_32 - 1);
      w_step = i_t1_ovf;
      unique case (i_mode)
         MODE0: begin
            w_last = 6'(DIV_12 - 1);
            w_step = 1'b1;
         end
         MODE2: begin
            w_last = i_smod ? 6'(DIV_32 - 1) : 6'(DIV_64 - 1);
            w_step = 1'b1;
         end
         MODE1, MODE3: begin
            w_last = i_smod ? 6'(DIV_32 / 2 - 1) : 6'(DIV_32 - 1);
            w_step = i_t1_ovf;
         end
         default: begin
            w_last = 6'(DIV_32 - 1);
            w_step = i_t1_ovf;
         end
      endcase
   end

   // >= rather than == so a smod change mid-period cannot overrun the counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_br  <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_br  <= 1'b0;
      end else begin
         r_br <= 1'b0;
         if (w_step) begin
            if (r_cnt >= w_last) begin
               r_cnt <= '0;
               r_br  <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 6'd1;
            end
         end
      end
   end

   assign o_br = r_br;

endmodule

// File: rtl/serial_ctrl.sv
// EMC08 serial port control: SCON/SBUF registers, SFR decode, TX sequencing,
// RX acceptance rules and the serial interrupt.
module serial_ctrl
   import serial_pkg::*;
#(
   parameter logic [7:0] SCON_ADDR = DEF_SCON_ADDR,
   parameter logic [7:0] SBUF_ADDR = DEF_SBUF_ADDR
)(
   input  logic       serial_clock_i,
   input  logic       serial_reset_i_b,
   input  logic [7:0] serial_sfr_addr_i,
   input  logic [7:0] serial_sfr_data_i,
   input  logic       serial_sfr_wr_i,
   input  logic       serial_sfr_rd_i,
   output logic [7:0] serial_sfr_data_o,
   input  logic       serial_smod_i,
   input  logic       serial_t1_ovf_i,
   input  logic       serial_rx_done_i,
   input  logic [7:0] serial_rx_sbuf_i,
   input  logic       serial_rx_rb8_i,
   input  logic       serial_tx_done_i,
   output logic       serial_tx_start_o,
   output logic [7:0] serial_tx_data_o,
   output logic       serial_tx_tb8_o,
   output logic       serial_rx_enable_o,
   output logic [1:0] serial_mode_o,
   output logic       serial_br_o,
   output logic       serial_irq_o
);

   tx_state_t  r_state, w_state_nxt;
   logic [7:0] r_scon, w_scon_nxt;
   logic [7:0] r_rx_sbuf;
   logic [7:0] r_tx_sbuf;
   logic [7:0] r_rd_data;
   logic       r_tx_start;

   logic       w_scon_wr;
   logic       w_sbuf_wr;
   logic [1:0] w_mode;
   logic       w_mode0;
   logic       w_rx_accept;
   logic       w_ti_set;
   logic       w_tx_load;
   logic       w_baud_clr;

   assign w_scon_wr  = serial_sfr_wr_i && (serial_sfr_addr_i == SCON_ADDR);
   assign w_sbuf_wr  = serial_sfr_wr_i && (serial_sfr_addr_i == SBUF_ADDR);
   assign w_mode     = r_scon[SCON_SM0:SCON_SM1];
   assign w_mode0    = (w_mode == MODE0);
   assign w_baud_clr = w_scon_wr && (serial_sfr_data_i[SCON_SM0:SCON_SM1] != w_mode);

   // Rejection uses the pre-write RI, so a CPU clear in the same cycle cannot admit a frame
   assign w_rx_accept = serial_rx_done_i &&
                        (w_mode0 || (!r_scon[SCON_RI] &&
                                     (!r_scon[SCON_SM2] || serial_rx_rb8_i)));

   always_comb begin
      w_state_nxt = r_state;
      w_ti_set    = 1'b0;
      w_tx_load   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_sbuf_wr) begin
               w_state_nxt = START;
               w_tx_load   = 1'b1;
            end
         end
         START: w_state_nxt = BUSY;
         BUSY: begin
            if (serial_tx_done_i) w_state_nxt = DONE;
         end
         DONE: begin
            w_ti_set    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Hardware sets of RI/TI override a same-cycle CPU write for those bits only
   always_comb begin
      w_scon_nxt = r_scon;
      if (w_scon_wr) w_scon_nxt = serial_sfr_data_i;
      if (w_rx_accept) begin
         w_scon_nxt[SCON_RI] = 1'b1;
         if (!w_mode0 && !w_scon_wr) w_scon_nxt[SCON_RB8] = serial_rx_rb8_i;
      end
      if (w_ti_set) w_scon_nxt[SCON_TI] = 1'b1;
   end

   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b) begin
         r_state    <= IDLE;
         r_scon     <= '0;
         r_rx_sbuf  <= '0;
         r_tx_sbuf  <= '0;
         r_rd_data  <= '0;
         r_tx_start <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_scon     <= w_scon_nxt;
         r_tx_start <= (w_state_nxt == START);
         if (w_tx_load) r_tx_sbuf <= serial_sfr_data_i;
         if (w_rx_accept) r_rx_sbuf <= serial_rx_sbuf_i;
         if (serial_sfr_rd_i) begin
            if (serial_sfr_addr_i == SCON_ADDR)      r_rd_data <= r_scon;
            else if (serial_sfr_addr_i == SBUF_ADDR) r_rd_data <= r_rx_sbuf;
            else                                     r_rd_data <= '0;
         end
      end
   end

   serial_baud_gen u_baud_gen (
      .i_clk    (serial_clock_i),
      .i_rst_n  (serial_reset_i_b),
      .i_clr    (w_baud_clr),
      .i_mode   (w_mode),
      .i_smod   (serial_smod_i),
      .i_t1_ovf (serial_t1_ovf_i),
      .o_br     (serial_br_o)
   );

   assign serial_sfr_data_o  = r_rd_data;
   assign serial_tx_start_o  = r_tx_start;
   assign serial_tx_data_o   = r_tx_sbuf;
   assign serial_tx_tb8_o    = r_scon[SCON_TB8];
   assign serial_mode_o      = w_mode;
   assign serial_rx_enable_o = w_mode0 ? (r_scon[SCON_REN] & ~r_scon[SCON_RI])
                                       : r_scon[SCON_REN];
   assign serial_irq_o       = r_scon[SCON_RI] | r_scon[SCON_TI];

endmodule

// File: tb/tb_serial_ctrl.sv
// Self-checking bench for serial_ctrl: directed scenarios plus randomized RX
// acceptance against a rule-level model of SCON and the receive buffer.
module tb_serial_ctrl;

   localparam logic [7:0] A_SCON = 8'h98;
   localparam logic [7:0] A_SBUF = 8'h99;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sfr_addr = '0;
   logic [7:0] sfr_wdata = '0;
   logic       sfr_wr = 1'b0;
   logic       sfr_rd = 1'b0;
   logic [7:0] sfr_rdata;
   logic       smod = 1'b0;
   logic       t1_ovf = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_byte = '0;
   logic       rx_rb8 = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_tb8;
   logic       rx_en;
   logic [1:0] mode;
   logic       br;
   logic       irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_ctrl dut (
      .serial_clock_i     (clk),
      .serial_reset_i_b   (rst_n),
      .serial_sfr_addr_i  (sfr_addr),
      .serial_sfr_data_i  (sfr_wdata),
      .serial_sfr_wr_i    (sfr_wr),
      .serial_sfr_rd_i    (sfr_rd),
      .serial_sfr_data_o  (sfr_rdata),
      .serial_smod_i      (smod),
      .serial_t1_ovf_i    (t1_ovf),
      .serial_rx_done_i   (rx_done),
      .serial_rx_sbuf_i   (rx_byte),
      .serial_rx_rb8_i    (rx_rb8),
      .serial_tx_done_i   (tx_done),
      .serial_tx_start_o  (tx_start),
      .serial_tx_data_o   (tx_data),
      .serial_tx_tb8_o    (tx_tb8),
      .serial_rx_enable_o (rx_en),
      .serial_mode_o      (mode),
      .serial_br_o        (br),
      .serial_irq_o       (irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
      sfr_addr = a; sfr_wdata = d; sfr_wr = 1'b1;
      tick();
      sfr_wr = 1'b0;
   endtask

   task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
      sfr_addr = a; sfr_rd = 1'b1;
      tick();
      sfr_rd = 1'b0;
      d = sfr_rdata;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic r);
      rx_done = 1'b1; rx_byte = b; rx_rb8 = r;
      tick();
      rx_done = 1'b0;
   endtask

   // clocks until the next br pulse, -1 if none within the budget
   task automatic measure_first(output int n);
      int i;
      n = -1; i = 0;
      while (n < 0 && i < 200) begin
         tick();
         i++;
         if (br) n = i;
      end
   endtask

   task automatic measure_period(output int n);
      int first;
      measure_first(first);
      if (first < 0) n = -1;
      else measure_first(n);
   endtask

   task automatic count_t1_pulses(output int n);
      int p;
      n = -1; p = 0;
      while (n < 0 && p < 80) begin
         t1_ovf = 1'b1;
         tick();
         t1_ovf = 1'b0;
         p++;
         if (br) n = p;
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      int n;
      repeat (3) tick();
      total++;
      if ({sfr_rdata, tx_start, tx_data, tx_tb8, rx_en, mode, br, irq} !== 23'd0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0",
                         {sfr_rdata, tx_start, tx_data, tx_tb8, rx_en, mode, br, irq});
      end
      rst_n = 1'b1;
      measure_first(n);
      total++;
      if (n !== 12) begin bad++; $display("FAIL reset_first_tick got=%0d exp=12", n); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL reset_scon got=%h exp=00", d); end
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL reset_sbuf got=%h exp=00", d); end
      sfr_read(8'h42, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL other_addr got=%h exp=00", d); end
   endtask

   task automatic test_mode0();
      logic [7:0] d;
      int n;
      sfr_write(A_SCON, 8'h10);
      total++;
      if (rx_en !== 1'b1) begin bad++; $display("FAIL m0_rx_en got=%b exp=1", rx_en); end
      measure_period(n);
      total++;
      if (n !== 12) begin bad++; $display("FAIL m0_period got=%0d exp=12", n); end
      rx_frame(8'hFC, 1'($urandom));
      total++;
      if ({irq, rx_en} !== 2'b10) begin bad++; $display("FAIL m0_rx_irq_en got=%b exp=10", {irq, rx_en}); end
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'hFC) begin bad++; $display("FAIL m0_sbuf got=%h exp=fc", d); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'h11) begin bad++; $display("FAIL m0_scon got=%h exp=11", d); end
   endtask

   task automatic test_mode2();
      logic [7:0] d;
      int n;
      smod = 1'b1;
      sfr_write(A_SCON, 8'hB0);
      measure_first(n);
      total++;
      if (n !== 32) begin bad++; $display("FAIL m2_first_tick got=%0d exp=32", n); end
      measure_first(n);
      total++;
      if (n !== 32) begin bad++; $display("FAIL m2_period got=%0d exp=32", n); end
      rx_frame(8'($urandom), 1'b0);
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'hFC) begin bad++; $display("FAIL m2_reject_sbuf got=%h exp=fc", d); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'hB0) begin bad++; $display("FAIL m2_reject_scon got=%h exp=b0", d); end
      rx_frame(8'hAA, 1'b1);
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'hAA) begin bad++; $display("FAIL m2_accept_sbuf got=%h exp=aa", d); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'hB5) begin bad++; $display("FAIL m2_accept_scon got=%h exp=b5", d); end
   endtask

   task automatic test_mode1();
      logic [7:0] d;
      int n;
      smod = 1'b0;
      sfr_write(A_SCON, 8'h51);
      total++;
      if ({mode, rx_en} !== 3'b011) begin bad++; $display("FAIL m1_mode_en got=%b exp=011", {mode, rx_en}); end
      count_t1_pulses(n);
      total++;
      if (n !== 32) begin bad++; $display("FAIL m1_t1_div32 got=%0d exp=32", n); end
      smod = 1'b1;
      count_t1_pulses(n);
      total++;
      if (n !== 16) begin bad++; $display("FAIL m1_t1_div16 got=%0d exp=16", n); end
      smod = 1'b0;
      rx_frame(8'h55, 1'b1);
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'hAA) begin bad++; $display("FAIL m1_ri_reject got=%h exp=aa", d); end
      sfr_write(A_SCON, 8'h50);
      rx_frame(8'h55, 1'b1);
      sfr_read(A_SBUF, d);
      total++;
      if (d !== 8'h55) begin bad++; $display("FAIL m1_resend_sbuf got=%h exp=55", d); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'h55) begin bad++; $display("FAIL m1_resend_scon got=%h exp=55", d); end
   endtask

   task automatic test_random_rx();
      logic [7:0] scon_m, sbuf_m, w, b, d;
      logic [1:0] m;
      logic sm2, ri0, r, sim, acc, en_m;
      sfr_write(A_SCON, 8'h10);
      rx_frame(8'h5A, 1'b0);
      sbuf_m = 8'h5A;
      for (int it = 0; it < 24; it++) begin
         m = 2'($urandom_range(0, 3)); sm2 = 1'($urandom); ri0 = 1'($urandom);
         r = 1'($urandom); b = 8'($urandom); sim = 1'($urandom);
         smod = 1'($urandom);
         scon_m = {m, sm2, 1'b1, 3'b000, ri0};
         sfr_write(A_SCON, scon_m);
         if (sim) begin
            // CPU clears RI in the very cycle the frame arrives
            w = {m, sm2, 1'b1, 1'b0, r, 2'b00};
            sfr_addr = A_SCON; sfr_wdata = w; sfr_wr = 1'b1;
            rx_done = 1'b1; rx_byte = b; rx_rb8 = r;
            tick();
            sfr_wr = 1'b0; rx_done = 1'b0;
            scon_m = w;
         end else begin
            rx_frame(b, r);
         end
         acc = (m == 2'd0) || (!ri0 && (!sm2 || r));
         if (acc) begin
            sbuf_m = b;
            scon_m[0] = 1'b1;
            if (m != 2'd0) scon_m[2] = r;
         end
         en_m = (m == 2'd0) ? (scon_m[4] & ~scon_m[0]) : scon_m[4];
         total++;
         if ({irq, rx_en, mode} !== {scon_m[0] | scon_m[1], en_m, m}) begin
            bad++; $display("FAIL rnd_outputs it=%0d got=%b exp=%b", it,
                            {irq, rx_en, mode}, {scon_m[0] | scon_m[1], en_m, m});
         end
         sfr_read(A_SCON, d);
         total++;
         if (d !== scon_m) begin bad++; $display("FAIL rnd_scon it=%0d got=%h exp=%h", it, d, scon_m); end
         sfr_read(A_SBUF, d);
         total++;
         if (d !== sbuf_m) begin bad++; $display("FAIL rnd_sbuf it=%0d got=%h exp=%h", it, d, sbuf_m); end
      end
   endtask

   task automatic test_tx();
      logic [7:0] d;
      sfr_write(A_SCON, 8'h00);
      sfr_write(A_SBUF, 8'h3C);
      total++;
      if ({tx_start, tx_data} !== {1'b1, 8'h3C}) begin
         bad++; $display("FAIL tx_start got=%b/%h exp=1/3c", tx_start, tx_data);
      end
      tick();
      total++;
      if (tx_start !== 1'b0) begin bad++; $display("FAIL tx_start_width got=%b exp=0", tx_start); end
      sfr_write(A_SBUF, 8'hFF);
      tick();
      total++;
      if ({tx_start, tx_data} !== {1'b0, 8'h3C}) begin
         bad++; $display("FAIL tx_busy_write got=%b/%h exp=0/3c", tx_start, tx_data);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL tx_ti_early got=%b exp=0", irq); end
      tick();
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL tx_ti_n2 got=%b exp=1", irq); end
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'h02) begin bad++; $display("FAIL tx_scon got=%h exp=02", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, b;
      b = 8'($urandom);
      sfr_write(A_SBUF, b);
      total++;
      if ({tx_start, tx_data} !== {1'b1, b}) begin
         bad++; $display("FAIL b2b_start got=%b/%h exp=1/%h", tx_start, tx_data, b);
      end
      tick();
      tx_done = 1'b1;
      tick();
      sfr_write(A_SCON, 8'h00);
      tx_done = 1'b0;
      sfr_read(A_SCON, d);
      total++;
      if (d !== 8'h02) begin bad++; $display("FAIL b2b_done_write got=%h exp=02", d); end
      sfr_write(A_SCON, 8'h00);
      repeat (3) tick();
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL b2b_done_extra got=%b exp=0", irq); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (2) tick();
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL b2b_idle_txdone got=%b exp=0", irq); end
   endtask

   task automatic test_reset_busy();
      logic [7:0] d;
      int starts;
      sfr_write(A_SCON, 8'h5A);
      sfr_read(A_SCON, d);
      total++;
      if ({tx_tb8, rx_en, mode, irq, d} !== {5'b11011, 8'h5A}) begin
         bad++; $display("FAIL rb_pre got=%b/%h exp=11011/5a", {tx_tb8, rx_en, mode, irq}, d);
      end
      sfr_write(A_SBUF, 8'h81);
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({sfr_rdata, tx_start, tx_data, tx_tb8, rx_en, mode, br, irq} !== 23'd0) begin
         bad++; $display("FAIL rb_async_clear got=%h exp=0",
                         {sfr_rdata, tx_start, tx_data, tx_tb8, rx_en, mode, br, irq});
      end
      repeat (2) tick();
      rst_n = 1'b1;
      starts = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_start) starts++;
      end
      total++;
      if (starts !== 0) begin bad++; $display("FAIL rb_no_start got=%0d exp=0", starts); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (2) tick();
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL rb_idle got=%b exp=0", irq); end
      sfr_write(A_SBUF, 8'h77);
      total++;
      if ({tx_start, tx_data} !== {1'b1, 8'h77}) begin
         bad++; $display("FAIL rb_restart got=%b/%h exp=1/77", tx_start, tx_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mode0();
      test_mode2();
      test_mode1();
      test_random_rx();
      test_tx();
      test_back_to_back();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
